// File: rtl/fetch_queue.sv
// Instruction fetch queue: a PC register drives a combinational instruction
// memory, and fetched {pc, instr} pairs are buffered in a circular FIFO until
// decode accepts them. A redirect flushes the queue and reloads the PC.
module fetch_queue #(
  parameter int               XLEN     = 64,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic [XLEN-1:0]              imem_addr,
  input  logic [31:0]                  imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [31:0]                  out_instr,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_pc;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  // Occupancy flags and the handshake qualifiers; redirect blocks both sides.
  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_empty = (r_count == '0);
    w_pop   = ~w_empty & out_ready & ~redirect;
    w_push  = ~redirect & ~stall & (~w_full | w_pop);
  end

  // Entry storage is data only; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_pc_mem[r_wptr]    <= r_pc;
      r_instr_mem[r_wptr] <= imem_rdata;
    end
  end

  // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + XLEN'(4);
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry and status are presented straight from registered state.
  always_comb begin
    imem_addr = r_pc;
    out_valid = ~w_empty;
    out_pc    = r_pc_mem[r_rptr];
    out_instr = r_instr_mem[r_rptr];
    count     = r_count;
    full      = w_full;
    empty     = w_empty;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference model tracks the PC and the
// queue contents, pushing expected entries as fetches happen and comparing
// them against the head as decode accepts them.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [2:0]      count;
  logic            full;
  logic            empty;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  ent_t            sb_q[$];
  logic [XLEN-1:0] m_pc;
  int              n_checks;
  int              n_errors;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check state against the model, advance the model, take the edge.
  task automatic cycle();
    logic do_pop;
    logic do_push;
    ent_t e;
    chk("count",     64'(count),     64'(sb_q.size()));
    chk("empty",     64'(empty),     64'(sb_q.size() == 0));
    chk("full",      64'(full),      64'(sb_q.size() == DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    if (!rst) begin
      m_pc = RESET_PC;
      sb_q.delete();
    end else if (redirect) begin
      m_pc = {redirect_pc[XLEN-1:2], 2'b00};
      sb_q.delete();
    end else begin
      do_pop  = (sb_q.size() != 0) && out_ready;
      do_push = !stall && ((sb_q.size() < DEPTH) || do_pop);
      if (do_pop) begin
        e = sb_q.pop_front();
        chk("out_pc",    64'(out_pc),    64'(e.pc));
        chk("out_instr", 64'(out_instr), 64'(e.instr));
      end
      if (do_push) begin
        sb_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [XLEN-1:0] rpc, input logic rdy, input int n);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; out_ready = rdy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    m_pc = RESET_PC;
    sb_q.delete();

    // Reset held; reset outputs compared at the next cycle's checks.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 2);

    // Streaming: one instruction per cycle, count settles at 1.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 8);
    chk("stream_count", 64'(count), 64'd1);

    // Fill from empty with decode blocked, then drain with continuous fetch.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 6);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_pc",   64'(imem_addr), 64'h10);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 6);
    chk("drain_count", 64'(count), 64'd4);

    // Redirect with 3 queued entries.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 3);
    chk("pre_redir_count", 64'(count), 64'd3);
    drive(1'b1, 1'b0, 1'b1, 32'h1002, 1'b1, 1);
    chk("redir_count", 64'(count), 64'd0);
    chk("redir_pc",    64'(imem_addr), 64'h1000);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);
    chk("redir_head_valid", 64'(out_valid), 64'd1);
    chk("redir_head_pc",    64'(out_pc), 64'h1000);

    // Stall drains the queue while the PC holds.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);
    chk("stall_pre_count", 64'(count), 64'd2);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 3);
    chk("stall_empty", 64'(out_valid), 64'd0);
    chk("stall_pc",    64'(imem_addr), 64'h1008);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 3);

    // Redirect during stall, then PC wrap at the top of the address space.
    drive(1'b1, 1'b1, 1'b1, 32'h2000, 1'b1, 1);
    chk("stall_redir_pc", 64'(imem_addr), 64'h2000);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1);
    chk("wrap_head0", 64'(out_pc), 64'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1);
    chk("wrap_head1", 64'(out_pc), 64'h0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 2);

    // Random mix of stall, ready and occasional redirects.
    for (int i = 0; i < 300; i++) begin
      rst         = 1'b1;
      stall       = ($urandom_range(0, 3) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom();
      cycle();
    end

    // Reset while full with redirect asserted: reset wins.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 5);
    chk("pre_rst_full", 64'(full), 64'd1);
    drive(1'b0, 1'b0, 1'b1, 32'h3000, 1'b1, 1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pc",    64'(imem_addr), 64'(RESET_PC));
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
